// File: rtl/sprite_palette_arbiter_if.sv
// Bundle of requester, palette and result-port signals for the sprite palette arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface sprite_palette_arbiter_if;
  logic       req0;
  logic [3:0] idx0;
  logic       req1;
  logic [3:0] idx1;
  logic       gnt0;
  logic       gnt1;
  logic [3:0] pal_index;
  logic [3:0] pal_red;
  logic [3:0] pal_green;
  logic [3:0] pal_blue;
  logic       out_ready;
  logic       out_valid;
  logic       out_id;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       transparent;

  modport slave (
    input  req0, idx0, req1, idx1,
    input  pal_red, pal_green, pal_blue,
    input  out_ready,
    output gnt0, gnt1, pal_index,
    output out_valid, out_id, red, green, blue, transparent
  );

  modport master (
    output req0, idx0, req1, idx1,
    output pal_red, pal_green, pal_blue,
    output out_ready,
    input  gnt0, gnt1, pal_index,
    input  out_valid, out_id, red, green, blue, transparent
  );
endinterface

// File: rtl/sprite_palette_arbiter.sv
// Round-robin arbiter sharing one combinational palette between two sprite renderers,
// with a single-entry registered result slot and colour-key transparency flag.
module sprite_palette_arbiter #(
  parameter logic [11:0] TRANSPARENT_RGB = 12'hF0F
) (
  input logic clk,
  input logic rst_n,
  sprite_palette_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CH_W  = 4;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            id_q;
  logic [CH_W-1:0] red_q, green_q, blue_q;
  logic            transparent_q;

  logic             slot_free_c;
  logic             gnt0_c, gnt1_c, any_gnt_c;
  logic [IDX_W-1:0] pal_index_c;
  logic [11:0]      pal_rgb_c;

  // Grant decision: a held result blocks new lookups until it is consumed.
  always_comb begin
    slot_free_c = (state_q == ST_EMPTY) || bus.out_ready;
    gnt0_c      = rst_n && slot_free_c && bus.req0 && (!bus.req1 || ptr_q);
    gnt1_c      = rst_n && slot_free_c && bus.req1 && (!bus.req0 || !ptr_q);
    any_gnt_c   = gnt0_c || gnt1_c;
    pal_index_c = IDX_W'(0);
    if (gnt0_c) begin
      pal_index_c = bus.idx0;
    end else if (gnt1_c) begin
      pal_index_c = bus.idx1;
    end
    pal_rgb_c = {bus.pal_red, bus.pal_green, bus.pal_blue};
  end

  // Next-state for the result slot and round-robin pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (any_gnt_c) begin
      ptr_d = gnt1_c;
    end
    case (state_q)
      ST_EMPTY: begin
        if (any_gnt_c) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.out_ready && !any_gnt_c) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Result payload is captured only on a grant and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q          <= 1'b0;
      red_q         <= CH_W'(0);
      green_q       <= CH_W'(0);
      blue_q        <= CH_W'(0);
      transparent_q <= 1'b0;
    end else if (any_gnt_c) begin
      id_q          <= gnt1_c;
      red_q         <= bus.pal_red;
      green_q       <= bus.pal_green;
      blue_q        <= bus.pal_blue;
      transparent_q <= (pal_rgb_c == TRANSPARENT_RGB);
    end
  end

  assign bus.gnt0        = gnt0_c;
  assign bus.gnt1        = gnt1_c;
  assign bus.pal_index   = pal_index_c;
  assign bus.out_valid   = (state_q == ST_FULL);
  assign bus.out_id      = id_q;
  assign bus.red         = red_q;
  assign bus.green       = green_q;
  assign bus.blue        = blue_q;
  assign bus.transparent = transparent_q;

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Directed, table-driven bench for sprite_palette_arbiter with a small palette model.
module tb_sprite_palette_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sprite_palette_arbiter_if bus ();

  sprite_palette_arbiter #(.TRANSPARENT_RGB(12'hF0F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pal_fn(input logic [3:0] i);
    logic [3:0] g;
    logic [3:0] b;
    if (i == 4'd1) return 12'hF0F;
    if (i == 4'd2) return 12'hE43;
    g = i + 4'd3;
    b = ~i;
    return {i, g, b};
  endfunction

  always_comb begin
    {bus.pal_red, bus.pal_green, bus.pal_blue} = pal_fn(bus.pal_index);
  end

  typedef struct {
    logic        req0;
    logic [3:0]  idx0;
    logic        req1;
    logic [3:0]  idx1;
    logic        rdy;
    logic        e_gnt0;
    logic        e_gnt1;
    logic [3:0]  e_pal;
    logic        e_valid;
    logic        e_id;
    logic [11:0] e_rgb;
    logic        e_trans;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic r0, input logic [3:0] i0, input logic r1,
                              input logic [3:0] i1, input logic rdy, input logic g0,
                              input logic g1, input logic [3:0] p, input logic v,
                              input logic id, input logic [11:0] rgb, input logic t);
    vec_t x;
    x.req0 = r0; x.idx0 = i0; x.req1 = r1; x.idx1 = i1; x.rdy = rdy;
    x.e_gnt0 = g0; x.e_gnt1 = g1; x.e_pal = p;
    x.e_valid = v; x.e_id = id; x.e_rgb = rgb; x.e_trans = t;
    return x;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic [3:0] i0, input logic r1,
                       input logic [3:0] i1, input logic rdy);
    bus.req0 = r0; bus.idx0 = i0; bus.req1 = r1; bus.idx1 = i1; bus.out_ready = rdy;
  endtask

  task automatic chk_result(input string tag, input logic v, input logic id,
                            input logic [11:0] rgb, input logic t);
    chk({tag, " out_valid"}, 12'(bus.out_valid), 12'(v));
    if (v) begin
      chk({tag, " out_id"}, 12'(bus.out_id), 12'(id));
      chk({tag, " rgb"}, {bus.red, bus.green, bus.blue}, rgb);
      chk({tag, " transparent"}, 12'(bus.transparent), 12'(t));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //            r0 i0 r1 i1 rdy  g0 g1 pal  v id rgb      t
    vecs[0]  = mk(1, 2, 0, 0, 1,   1, 0, 2,   1, 0, 12'hE43, 0);
    vecs[1]  = mk(0, 0, 1, 1, 1,   0, 1, 1,   1, 1, 12'hF0F, 1);
    vecs[2]  = mk(1, 3, 1, 4, 1,   1, 0, 3,   1, 0, 12'h36C, 0);
    vecs[3]  = mk(1, 3, 1, 4, 1,   0, 1, 4,   1, 1, 12'h47B, 0);
    vecs[4]  = mk(1, 3, 1, 4, 1,   1, 0, 3,   1, 0, 12'h36C, 0);
    vecs[5]  = mk(1, 3, 1, 4, 1,   0, 1, 4,   1, 1, 12'h47B, 0);
    vecs[6]  = mk(1, 3, 1, 4, 0,   0, 0, 0,   1, 1, 12'h47B, 0);
    vecs[7]  = mk(1, 3, 1, 4, 0,   0, 0, 0,   1, 1, 12'h47B, 0);
    vecs[8]  = mk(1, 3, 1, 4, 0,   0, 0, 0,   1, 1, 12'h47B, 0);
    vecs[9]  = mk(1, 3, 1, 4, 1,   1, 0, 3,   1, 0, 12'h36C, 0);
    vecs[10] = mk(0, 0, 0, 0, 1,   0, 0, 0,   0, 0, 12'h000, 0);
    vecs[11] = mk(0, 0, 0, 0, 1,   0, 0, 0,   0, 0, 12'h000, 0);
    vecs[12] = mk(0, 0, 1, 5, 0,   0, 1, 5,   1, 1, 12'h58A, 0);
    vecs[13] = mk(1, 6, 0, 0, 0,   0, 0, 0,   1, 1, 12'h58A, 0);
    vecs[14] = mk(0, 6, 0, 0, 1,   0, 0, 0,   0, 0, 12'h000, 0);

    // Reset state, with a request pending to show grants are suppressed.
    rst_n = 1'b0;
    drive(1, 4'd2, 1, 4'd1, 1);
    #1;
    chk("rst gnt0", 12'(bus.gnt0), 12'h0);
    chk("rst gnt1", 12'(bus.gnt1), 12'h0);
    chk("rst pal_index", 12'(bus.pal_index), 12'h0);
    chk("rst out_valid", 12'(bus.out_valid), 12'h0);
    chk("rst out_id", 12'(bus.out_id), 12'h0);
    chk("rst rgb", {bus.red, bus.green, bus.blue}, 12'h000);
    chk("rst transparent", 12'(bus.transparent), 12'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].req0, vecs[i].idx0, vecs[i].req1, vecs[i].idx1, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d gnt0", i), 12'(bus.gnt0), 12'(vecs[i].e_gnt0));
      chk($sformatf("v%0d gnt1", i), 12'(bus.gnt1), 12'(vecs[i].e_gnt1));
      chk($sformatf("v%0d pal_index", i), 12'(bus.pal_index), 12'(vecs[i].e_pal));
      @(posedge clk);
      #1;
      chk_result($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_id,
                 vecs[i].e_rgb, vecs[i].e_trans);
    end

    // Fill the slot (pointer now points at requester 0), then reset mid-stream.
    @(negedge clk);
    drive(1, 4'd2, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_result("fill", 1, 0, 12'hE43, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 12'(bus.out_valid), 12'h0);
    chk("midrst gnt0", 12'(bus.gnt0), 12'h0);
    chk("midrst pal_index", 12'(bus.pal_index), 12'h0);
    chk("midrst rgb", {bus.red, bus.green, bus.blue}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 4'd3, 1, 4'd4, 1);
    #1;
    chk("post-rst gnt0", 12'(bus.gnt0), 12'h1);
    chk("post-rst gnt1", 12'(bus.gnt1), 12'h0);
    chk("post-rst pal_index", 12'(bus.pal_index), 12'h3);
    @(posedge clk);
    #1;
    chk_result("post-rst r0", 1, 0, 12'h36C, 0);
    @(negedge clk);
    #1;
    chk("post-rst2 gnt1", 12'(bus.gnt1), 12'h1);
    chk("post-rst2 pal_index", 12'(bus.pal_index), 12'h4);
    @(posedge clk);
    #1;
    chk_result("post-rst r1", 1, 1, 12'h47B, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
